// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, opcode/funct
// encodings and the FSM state type.
package alu_issue_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int OPRN_W = 6;

  localparam logic [5:0] ALU_OPR_NOP = 6'd0;
  localparam logic [5:0] ALU_OPR_ADD = 6'd1;
  localparam logic [5:0] ALU_OPR_SUB = 6'd2;
  localparam logic [5:0] ALU_OPR_MUL = 6'd3;
  localparam logic [5:0] ALU_OPR_SRL = 6'd4;
  localparam logic [5:0] ALU_OPR_SLL = 6'd5;
  localparam logic [5:0] ALU_OPR_AND = 6'd6;
  localparam logic [5:0] ALU_OPR_OR  = 6'd7;
  localparam logic [5:0] ALU_OPR_NOR = 6'd8;
  localparam logic [5:0] ALU_OPR_SLT = 6'd9;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_MULI  = 6'h1D;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2C;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decode: picks the ALU op code, operands and
// destination register, and flags anything that is not an ALU instruction.
module alu_issue_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int OPRN_WIDTH = OPRN_W
) (
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [OPRN_WIDTH-1:0] oprn,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic [4:0]            dest,
  output logic                  illegal
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [5:0]            code;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;
  logic [DATA_WIDTH-1:0] shamt_zext;
  logic [4:0]            unused_rs_field;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign imm_sext        = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
  assign imm_zext        = {{(DATA_WIDTH-16){1'b0}}, instr[15:0]};
  assign shamt_zext      = {{(DATA_WIDTH-5){1'b0}}, instr[10:6]};
  // The rs field only selects a register upstream; its value arrives as rs_data.
  assign unused_rs_field = instr[25:21];

  always_comb begin
    code    = ALU_OPR_NOP;
    op1     = rs_data;
    op2     = rt_data;
    dest    = instr[15:11];
    illegal = 1'b0;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FN_ADD: code = ALU_OPR_ADD;
        FN_SUB: code = ALU_OPR_SUB;
        FN_MUL: code = ALU_OPR_MUL;
        FN_AND: code = ALU_OPR_AND;
        FN_OR:  code = ALU_OPR_OR;
        FN_NOR: code = ALU_OPR_NOR;
        FN_SLT: code = ALU_OPR_SLT;
        FN_SRL: begin code = ALU_OPR_SRL; op1 = rt_data; op2 = shamt_zext; end
        FN_SLL: begin code = ALU_OPR_SLL; op1 = rt_data; op2 = shamt_zext; end
        default: illegal = 1'b1;
      endcase
    end else begin
      dest = instr[20:16];
      op2  = imm_sext;
      case (opcode)
        OPC_ADDI: code = ALU_OPR_ADD;
        OPC_MULI: code = ALU_OPR_MUL;
        OPC_SLTI: code = ALU_OPR_SLT;
        OPC_ANDI: begin code = ALU_OPR_AND; op2 = imm_zext; end
        OPC_ORI:  begin code = ALU_OPR_OR;  op2 = imm_zext; end
        default:  illegal = 1'b1;
      endcase
    end
    if (illegal) begin
      code = ALU_OPR_NOP;
      op1  = '0;
      op2  = '0;
      dest = 5'd0;
    end
  end

  assign oprn = OPRN_WIDTH'(code);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded packet to the combinational ALU for a single cycle and
// holds the captured result for writeback under valid/ready.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_DRIVE | ALU driven with latched op code and operands (one cycle)
// ST_RESP  | result packet valid, waiting for out_ready
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int OPRN_WIDTH = OPRN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [OPRN_WIDTH-1:0] alu_oprn,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_zero,
  output logic [4:0]            res_dest,
  output logic                  res_err
);

  state_t                state;
  logic [4:0]            dest_q;
  logic [OPRN_WIDTH-1:0] dec_oprn;
  logic [DATA_WIDTH-1:0] dec_op1;
  logic [DATA_WIDTH-1:0] dec_op2;
  logic [4:0]            dec_dest;
  logic                  dec_illegal;

  alu_issue_decode #(
    .DATA_WIDTH(DATA_WIDTH),
    .OPRN_WIDTH(OPRN_WIDTH)
  ) u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .oprn    (dec_oprn),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .dest    (dec_dest),
    .illegal (dec_illegal)
  );

  // alu_oprn is loaded on entry to ST_DRIVE and cleared on exit, so it is
  // non-zero for exactly that one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      alu_oprn  <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
      dest_q    <= 5'd0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_dest  <= 5'd0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (dec_illegal) begin
              res_err   <= 1'b1;
              res_data  <= '0;
              res_zero  <= 1'b0;
              res_dest  <= 5'd0;
              out_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_op1  <= dec_op1;
              alu_op2  <= dec_op2;
              alu_oprn <= dec_oprn;
              dest_q   <= dec_dest;
              state    <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          alu_oprn  <= '0;
          res_data  <= alu_out;
          res_zero  <= alu_zero;
          res_dest  <= dest_q;
          res_err   <= 1'b0;
          out_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          alu_oprn  <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
